rgmii_phy_link_monitor: RTL and testbench
=========================================

Name: rgmii_phy_link_monitor

Overview:
- MDIO (IEEE 802.3 Clause 22) master that periodically polls an external RGMII PHY for link, speed and duplex.
- Drives the speed_selection and duplex_mode configuration inputs of the RGMII/GMII bridge.
- Sits in the management clock domain beside the bridge; its outputs are quasi-static and are synchronised by their consumer.

Parameters:
- MDC_DIV, 25, clk cycles per MDC half-period (MDC = clk/(2*MDC_DIV)); minimum 2.
- POLL_CYCLES, 1000000, idle clk cycles between the end of one poll and the start of the next.
- PHY_ADDR, 5'h01, default PHY address loaded at reset.
- STAT_REG, 5'h11, PHY-specific status register address.
- SPEED_MSB, 15, MSB of the 2-bit speed field in STAT_REG (field is [SPEED_MSB:SPEED_MSB-1]).
- DUPLEX_BIT, 13, full-duplex bit in STAT_REG.

Ports:
- clk  in  1  management clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  polling enabled
- poll_now  in  1  single-cycle pulse; start a poll immediately if idle
- phy_addr  in  5  PHY address, sampled at each poll start
- mdc  out  1  MDIO clock
- mdio_o  out  1  MDIO data out
- mdio_oe  out  1  MDIO output enable; tristate buffer is external
- mdio_i  in  1  MDIO data in
- link_up  out  1  link status (BMSR bit 2)
- speed_selection  out  2  00=10M, 01=100M, 10=1000M
- duplex_mode  out  1  1 = full duplex
- status_valid  out  1  one-cycle pulse when a complete poll updates the outputs
- busy  out  1  MDIO transaction in progress

Behaviour:
- Reset values: mdc=0, mdio_o=1, mdio_oe=0, link_up=0, speed_selection=2'b10, duplex_mode=1, status_valid=0, busy=0. FSM goes to IDLE; poll timer is loaded with 0 so the first poll starts as soon as enable=1.
- MDC generation:
  - The divider runs only while busy; mdc is held at 0 in IDLE.
  - A terminal count (MDC_DIV-1) toggles mdc. A 0->1 toggle is a "rise" event; a 1->0 toggle is a "fall" event.
  - mdio_o and mdio_oe change only on fall events. mdio_i is sampled in the clk cycle of each rise event.
- FSM states: IDLE -> PRE -> HDR -> TA -> DATA -> NEXT -> (PRE or IDLE).
  - IDLE: decrement the poll timer while enable=1. Leave IDLE when the timer reaches 0 or when poll_now=1. On leaving: latch phy_addr, select register 1 (BMSR), set busy=1.
  - PRE: 32 MDC bits of 1, oe=1.
  - HDR: 14 bits, MSB first: ST=01, OP=10 (read), PHYAD[4:0], REGAD[4:0], oe=1.
  - TA: oe drops to 0 on the first TA fall. Two MDC bits; the PHY's TA bit is ignored.
  - DATA: 16 bits sampled MSB first on rise events into a shift register.
  - NEXT: after the BMSR read, capture bit 2, select STAT_REG and return to PRE. After the STAT_REG read, update the outputs, pulse status_valid, reload the timer with POLL_CYCLES-1, clear busy, go to IDLE. mdc ends low.
- Output update rules:
  - link_up = BMSR[2].
  - When link_up=1: speed_selection = STAT[SPEED_MSB:SPEED_MSB-1] and duplex_mode = STAT[DUPLEX_BIT]. A speed field of 11 is reserved; the previous speed is held.
  - When link_up=0: speed_selection and duplex_mode hold their previous values.
- Frame size: each read is 64 MDC periods; a full poll is 128 MDC periods = 256*MDC_DIV clk cycles.
- Boundary cases:
  - poll_now while busy is ignored.
  - enable dropping mid-poll does not abort; the current poll completes, then the FSM stays in IDLE.
  - poll_now works even when enable=0.
  - Reset mid-frame immediately forces oe=0, mdc=0 and the reset values.
- Counters:
  - The bit counter is 6 bits and counts 0-based within each state.
  - The poll timer is $clog2(POLL_CYCLES) bits and saturates at 0.

Optional Feature:
- Macro: LINK_MONITOR_IRQ_EN.
- Defined: adds output port link_irq (1 bit, reset 0). It pulses for one cycle, coincident with status_valid, when link_up, speed_selection or duplex_mode differs from its pre-update value.
- Undefined: no link_irq port and no change-detection logic.

Test Plan:
- Reset, enable=1, MDC_DIV=2, PHY model at address 1 with BMSR=16'h0004 and STAT=16'hA000 -> first frame on mdio_o is 32 ones then 0110_00001_00001. Then link_up=1, speed_selection=10, duplex_mode=1, one status_valid pulse 512 clk cycles after the poll starts.
- PHY returns BMSR=16'h0000 -> link_up=0; speed and duplex hold their prior values (10, 1).
- STAT=16'h4000 with link up -> speed_selection=01, duplex_mode=0. Then STAT=16'hC000 -> speed holds at 01.
- poll_now pulsed mid-poll -> no extra frame. After returning to IDLE with enable=0, a poll_now pulse -> exactly one poll.
- Check mdio_oe deasserts at the first TA bit. Assert reset during the DATA state -> mdio_oe=0, mdc=0, outputs at reset values within one cycle.
- With LINK_MONITOR_IRQ_EN: speed change from 10 to 01 -> one link_irq pulse. An identical repeat poll -> no pulse.

Source files
------------

// File: rtl/rgmii_phy_link_monitor.sv
// rgmii_phy_link_monitor: Clause 22 MDIO poller that reads BMSR and a PHY status
// register to drive the RGMII bridge speed_selection / duplex_mode inputs.
// Optional link_irq change-pulse output is built when LINK_MONITOR_IRQ_EN is defined.
module rgmii_phy_link_monitor #(
    parameter int         MDC_DIV     = 25,
    parameter int         POLL_CYCLES = 1000000,
    parameter logic [4:0] PHY_ADDR    = 5'h01,
    parameter logic [4:0] STAT_REG    = 5'h11,
    parameter int         SPEED_MSB   = 15,
    parameter int         DUPLEX_BIT  = 13
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       poll_now,
    input  logic [4:0] phy_addr,
    output logic       mdc,
    output logic       mdio_o,
    output logic       mdio_oe,
    input  logic       mdio_i,
    output logic       link_up,
    output logic [1:0] speed_selection,
    output logic       duplex_mode,
    output logic       status_valid,
    output logic       busy
`ifdef LINK_MONITOR_IRQ_EN
    ,
    output logic       link_irq
`endif
);

    localparam int DIV_W = (MDC_DIV > 2) ? $clog2(MDC_DIV) : 1;
    localparam int TMR_W = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_TC     = DIV_W'(MDC_DIV - 1);
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(POLL_CYCLES - 1);
    localparam logic [4:0]       BMSR_REG   = 5'h01;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_HDR  = 3'd2;
    localparam logic [2:0] S_TA   = 3'd3;
    localparam logic [2:0] S_DATA = 3'd4;
    localparam logic [2:0] S_NEXT = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             mdc_q, mdc_d;
    logic             mdo_q, mdo_d;
    logic             oe_q, oe_d;
    logic [5:0]       bit_q, bit_d;
    logic [15:0]      sh_q, sh_d;
    logic             sel_q, sel_d;
    logic [4:0]       addr_q, addr_d;
    logic             blink_q, blink_d;
    logic             link_q, link_d;
    logic [1:0]       speed_q, speed_d;
    logic             duplex_q, duplex_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;

    logic             tc, rise, fall;
    logic [13:0]      hdr;
    logic [1:0]       stat_speed, new_speed;
    logic             new_duplex;

    // MDC divider: free-runs only during a transaction, parks low otherwise
    always_comb begin
        tc    = busy_q && (div_q == DIV_TC);
        rise  = tc && !mdc_q;
        fall  = tc && mdc_q;
        div_d = (!busy_q || tc) ? '0 : div_q + 1'b1;
        mdc_d = busy_q ? (mdc_q ^ tc) : 1'b0;
    end

    // Read header and the status values a finished poll would publish
    always_comb begin
        hdr        = {4'b0110, addr_q, sel_q ? STAT_REG : BMSR_REG};
        stat_speed = sh_q[SPEED_MSB -: 2];
        new_speed  = (blink_q && stat_speed != 2'b11) ? stat_speed : speed_q;
        new_duplex = blink_q ? sh_q[DUPLEX_BIT] : duplex_q;
    end

    // Frame sequencer: bits are launched on MDC falls and captured on MDC rises
    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        sel_d    = sel_q;
        addr_d   = addr_q;
        blink_d  = blink_q;
        link_d   = link_q;
        speed_d  = speed_q;
        duplex_d = duplex_q;
        valid_d  = 1'b0;
        busy_d   = busy_q;
        tmr_d    = tmr_q;
        mdo_d    = mdo_q;
        oe_d     = oe_q;
        case (state_q)
            S_IDLE: begin
                if (enable && tmr_q != '0)
                    tmr_d = tmr_q - 1'b1;
                if (poll_now || (enable && tmr_q == '0)) begin
                    state_d = S_PRE;
                    addr_d  = phy_addr;
                    sel_d   = 1'b0;
                    busy_d  = 1'b1;
                    bit_d   = '0;
                    oe_d    = 1'b1;
                    mdo_d   = 1'b1;
                end
            end
            S_PRE: begin
                if (fall) begin
                    bit_d = bit_q + 6'd1;
                    if (bit_q == 6'd31) begin
                        state_d = S_HDR;
                        bit_d   = '0;
                        sh_d    = {hdr, 2'b11};
                        mdo_d   = hdr[13];
                    end
                end
            end
            S_HDR: begin
                if (fall) begin
                    bit_d = bit_q + 6'd1;
                    sh_d  = {sh_q[14:0], 1'b1};
                    mdo_d = sh_q[14];
                    if (bit_q == 6'd13) begin
                        state_d = S_TA;
                        bit_d   = '0;
                        oe_d    = 1'b0;
                        mdo_d   = 1'b1;
                    end
                end
            end
            S_TA: begin
                if (fall) begin
                    bit_d = bit_q + 6'd1;
                    if (bit_q == 6'd1) begin
                        state_d = S_DATA;
                        bit_d   = '0;
                    end
                end
            end
            S_DATA: begin
                if (rise) begin
                    sh_d = {sh_q[14:0], mdio_i};
                    if (bit_q == 6'd15)
                        state_d = S_NEXT;
                end else if (fall) begin
                    bit_d = bit_q + 6'd1;
                end
            end
            S_NEXT: begin
                // Waits out the high half of the last data bit so the frame ends on a fall
                if (fall) begin
                    if (!sel_q) begin
                        blink_d = sh_q[2];
                        sel_d   = 1'b1;
                        state_d = S_PRE;
                        bit_d   = '0;
                        oe_d    = 1'b1;
                        mdo_d   = 1'b1;
                    end else begin
                        link_d   = blink_q;
                        speed_d  = new_speed;
                        duplex_d = new_duplex;
                        valid_d  = 1'b1;
                        tmr_d    = TMR_RELOAD;
                        busy_d   = 1'b0;
                        state_d  = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with asynchronous reset to the idle, safe-bus values
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            mdc_q    <= 1'b0;
            mdo_q    <= 1'b1;
            oe_q     <= 1'b0;
            bit_q    <= '0;
            sh_q     <= '0;
            sel_q    <= 1'b0;
            addr_q   <= PHY_ADDR;
            blink_q  <= 1'b0;
            link_q   <= 1'b0;
            speed_q  <= 2'b10;
            duplex_q <= 1'b1;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            tmr_q    <= '0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            mdc_q    <= mdc_d;
            mdo_q    <= mdo_d;
            oe_q     <= oe_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            sel_q    <= sel_d;
            addr_q   <= addr_d;
            blink_q  <= blink_d;
            link_q   <= link_d;
            speed_q  <= speed_d;
            duplex_q <= duplex_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            tmr_q    <= tmr_d;
        end
    end

`ifdef LINK_MONITOR_IRQ_EN
    logic irq_q, irq_d;

    // Flag a poll whose published status differs from what was reported before
    always_comb begin
        irq_d = valid_d && ({link_d, speed_d, duplex_d} != {link_q, speed_q, duplex_q});
    end

    // Change-pulse register, aligned with status_valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            irq_q <= 1'b0;
        else
            irq_q <= irq_d;
    end

    assign link_irq = irq_q;
`endif

    assign mdc             = mdc_q;
    assign mdio_o          = mdo_q;
    assign mdio_oe         = oe_q;
    assign link_up         = link_q;
    assign speed_selection = speed_q;
    assign duplex_mode     = duplex_q;
    assign status_valid    = valid_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_rgmii_phy_link_monitor.sv
// tb_rgmii_phy_link_monitor: directed + random polls against a Clause 22 PHY model
module tb_rgmii_phy_link_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       poll_now;
    logic [4:0] phy_addr;
    logic       mdc, mdio_o, mdio_oe;
    logic       mdio_i = 1'b1;
    logic       link_up;
    logic [1:0] speed_selection;
    logic       duplex_mode, status_valid, busy;
`ifdef LINK_MONITOR_IRQ_EN
    logic       link_irq;
`endif

    int checks = 0;
    int failures = 0;

    rgmii_phy_link_monitor #(.MDC_DIV(2), .POLL_CYCLES(64)) dut (
        .clk(clk), .reset(reset), .enable(enable), .poll_now(poll_now),
        .phy_addr(phy_addr), .mdc(mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe),
        .mdio_i(mdio_i), .link_up(link_up), .speed_selection(speed_selection),
        .duplex_mode(duplex_mode), .status_valid(status_valid), .busy(busy)
`ifdef LINK_MONITOR_IRQ_EN
        , .link_irq(link_irq)
`endif
    );

    always #5 clk = ~clk;

    // PHY model: counts MDC rises within each 64-bit frame, records the
    // management frame and answers with the register named in its header
    logic [15:0] bmsr, stat, word;
    logic [45:0] fb;
    logic        oe_all, ta_any;
    int          r = 0;
    logic [47:0] frames[$];

    always @(posedge mdc or posedge reset) begin
        if (reset) begin
            r = 0;
        end else begin
            if (r == 0) begin
                oe_all = 1'b1;
                ta_any = 1'b0;
            end
            if (r < 46) begin
                fb[6'(45 - r)] = mdio_o;
                oe_all = oe_all & mdio_oe;
            end else if (r < 48) begin
                ta_any = ta_any | mdio_oe;
            end
            if (r == 47)
                frames.push_back({oe_all, ta_any, fb});
            r = (r == 63) ? 0 : r + 1;
        end
    end

    always @(negedge mdc) begin
        if (r >= 48) begin
            word = (fb[4:0] == 5'h01) ? bmsr : (fb[4:0] == 5'h11) ? stat : 16'hFFFF;
            mdio_i = word[4'(63 - r)];
        end else begin
            mdio_i = 1'b1;
        end
    end

    // Expected status: what a correct monitor reports after each poll
    logic       e_link = 1'b0;
    logic [1:0] e_speed = 2'b10;
    logic       e_dup = 1'b1;
    logic       e_irq = 1'b0;

    task automatic set_phy(input logic [15:0] b, input logic [15:0] s);
        logic [3:0] prev;
        bmsr = b;
        stat = s;
        prev = {e_link, e_speed, e_dup};
        e_link = b[2];
        if (e_link) begin
            if (s[15:14] != 2'b11)
                e_speed = s[15:14];
            e_dup = s[13];
        end
        e_irq = (prev != {e_link, e_speed, e_dup});
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_link"}, link_up, e_link);
        chk({tag, "_speed"}, speed_selection, e_speed);
        chk({tag, "_duplex"}, duplex_mode, e_dup);
`ifdef LINK_MONITOR_IRQ_EN
        chk({tag, "_irq"}, link_irq, e_irq);
`endif
    endtask

    task automatic wait_poll(input string tag, input int exp_gap);
        int n;
        n = 0;
        while (!busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (exp_gap >= 0)
            chk({tag, "_gap"}, n + 1, exp_gap);
        n = 0;
        while (!status_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, n, 512);
        check_outputs(tag);
        @(negedge clk);
        chk({tag, "_pulse"}, status_valid, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bc, f0;
        logic [47:0] fr;
        reset = 1'b1;
        enable = 1'b0;
        poll_now = 1'b0;
        phy_addr = 5'h01;
        bmsr = 16'h0;
        stat = 16'h0;
        repeat (3) @(negedge clk);
        chk("rst_mdc", mdc, 0);
        chk("rst_mdio_o", mdio_o, 1);
        chk("rst_oe", mdio_oe, 0);
        chk("rst_link", link_up, 0);
        chk("rst_speed", speed_selection, 2'b10);
        chk("rst_duplex", duplex_mode, 1);
        chk("rst_valid", status_valid, 0);
        chk("rst_busy", busy, 0);
`ifdef LINK_MONITOR_IRQ_EN
        chk("rst_irq", link_irq, 0);
`endif
        set_phy(16'h0004, 16'hA000);
        reset = 1'b0;
        enable = 1'b1;
        wait_poll("first", -1);
        chk("first_frames", frames.size(), 2);
        fr = (frames.size() > 0) ? frames.pop_front() : '0;
        chk("frame0_bits", fr[45:0], {32'hFFFF_FFFF, 4'b0110, 5'h01, 5'h01});
        chk("frame0_oe_hdr", fr[47], 1);
        chk("frame0_oe_ta", fr[46], 0);
        fr = (frames.size() > 0) ? frames.pop_front() : '0;
        chk("frame1_bits", fr[45:0], {32'hFFFF_FFFF, 4'b0110, 5'h01, 5'h11});
        chk("frame1_oe_ta", fr[46], 0);

        set_phy(16'h0000, 16'h4000);
        wait_poll("linkdown", 64);
        set_phy(16'h0004, 16'h4000);
        wait_poll("speed100", 64);
        set_phy(16'h0004, 16'hC000);
        wait_poll("reserved", 64);

        for (int i = 0; i < 6; i++) begin
            logic [15:0] b;
            b = 16'($urandom);
            b[2] = ($urandom_range(0, 3) != 0);
            set_phy(b, 16'($urandom));
            wait_poll($sformatf("rnd%0d", i), 64);
        end

        set_phy(16'h0004, 16'h4000);
        n = 0;
        while (!busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (100) @(negedge clk);
        enable = 1'b0;
        n = 0;
        while (!status_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("endrop_valid", status_valid, 1);
        check_outputs("endrop");
        bc = 0;
        repeat (300) begin
            @(negedge clk);
            if (busy) bc++;
        end
        chk("endrop_idle", bc, 0);

        f0 = frames.size();
        set_phy(16'h0004, 16'h4000);
        poll_now = 1'b1;
        @(negedge clk);
        poll_now = 1'b0;
        fork
            wait_poll("pollnow", -1);
            begin
                repeat (200) @(negedge clk);
                poll_now = 1'b1;
                @(negedge clk);
                poll_now = 1'b0;
            end
        join
        bc = 0;
        repeat (1000) begin
            @(negedge clk);
            if (busy) bc++;
        end
        chk("pollnow_idle", bc, 0);
        chk("pollnow_frames", frames.size() - f0, 2);

        poll_now = 1'b1;
        @(negedge clk);
        poll_now = 1'b0;
        n = 0;
        while (r < 50 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("mid_data_reached", (r >= 50), 1);
        chk("mid_data_oe", mdio_oe, 0);
        reset = 1'b1;
        #1;
        chk("midrst_oe", mdio_oe, 0);
        chk("midrst_mdc", mdc, 0);
        chk("midrst_mdio_o", mdio_o, 1);
        chk("midrst_link", link_up, 0);
        chk("midrst_speed", speed_selection, 2'b10);
        chk("midrst_duplex", duplex_mode, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", status_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
